spi_xact_arb: RTL
=================

Name: spi_xact_arb

Overview:
- Shares one SPI master transaction engine (16-bit wrt/done handshake) between the inertial interface (flight-critical) and the A2D battery interface.
- Arbitrates requests and launches one transaction at a time. Routes the read data and a done pulse back to the winning requester.
- Guards against starvation of the A2D requester and against a hung SPI engine.
- Sits between inert_intf/A2D_intf and the single SPI master in the QuadCopter top level.

Parameters:
- MAX_DEFER, 4: consecutive inertial grants allowed while an A2D request is pending before the A2D requester is forced to win.
- TIMEOUT, 1024: clock cycles allowed from wrt to done_spi before the transaction is aborted.
- TO_W, 11: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock (50MHz).
- rst  in  1  synchronous, active-high reset.
- req_inrt  in  1  inertial request, level; held until done_inrt.
- cmd_inrt  in  16  inertial SPI command word.
- done_inrt  out  1  one-cycle pulse: inertial transaction finished.
- rd_inrt  out  16  read data for the inertial requester; valid with done_inrt and held until the next inertial done.
- req_a2d  in  1  A2D request, level; held until done_a2d.
- cmd_a2d  in  16  A2D SPI command word.
- done_a2d  out  1  one-cycle pulse: A2D transaction finished.
- rd_a2d  out  16  read data for the A2D requester; held like rd_inrt.
- wrt  out  1  one-cycle pulse that starts an SPI transaction.
- cmd  out  16  command word to the SPI master; registered, stable from wrt until done_spi.
- done_spi  in  1  SPI master completion pulse.
- rd_spi  in  16  SPI master read data; valid with done_spi.
- busy  out  1  high from grant until the requester's done pulse.
- err  out  1  high with done_x when the transaction timed out; low otherwise.

Behaviour:
- Reset (rst high at a clk edge): state IDLE. All outputs 0, rd_inrt and rd_a2d = 16'h0000, defer counter = 0, timeout counter = 0. Reset mid-transfer aborts immediately with no done pulse; the SPI master shares rst.
- States: IDLE, XFER, RESP.
- IDLE:
  - If any req is high, grant at edge N: latch the owner, register cmd from the owner's cmd_x, assert wrt for exactly cycle N+1, set busy, go to XFER.
  - No grant when both reqs are low.
- Priority:
  - Inertial wins a simultaneous request unless defer_cnt == MAX_DEFER; in that case A2D wins.
  - defer_cnt increments on each inertial grant made while req_a2d is high, saturating at MAX_DEFER. It clears on any A2D grant.
- XFER:
  - Timeout counter runs from wrt.
  - On done_spi: capture rd_spi into the owner's rd_x, err = 0, go to RESP.
  - If the counter reaches TIMEOUT first: leave the owner's rd_x unchanged, err = 1, go to RESP. A done_spi arriving later is ignored.
- RESP (one cycle):
  - Pulse the owner's done_x, present err, clear busy, return to IDLE.
  - The next grant is no earlier than the cycle after RESP; a requester re-asserting req back-to-back sees one idle cycle.
- Latency: req high at edge N gives wrt at N+1. done_spi at edge M gives done_x and rd_x at M+1.
- Requester drops req mid-transfer: the transaction still completes and done_x still pulses.
- cmd_x changing after grant has no effect.
- done_spi while in IDLE or RESP: ignored, no output change.
- Non-owner outputs (done, rd) never change during another requester's transaction.

Decomposition:
- Shared package (quad_pkg):
  - State enum {IDLE, XFER, RESP}.
  - Owner encoding OWN_INRT = 1'b0, OWN_A2D = 1'b1.
  - Defaults for MAX_DEFER and TIMEOUT.
- No sub-module; the timeout counter and defer counter stay inline.

Test Plan:
1. req_inrt with cmd_inrt=16'hA2xx, done_spi 40 cycles after wrt with rd_spi=16'h1234 -> wrt 1 cycle after req, cmd=16'hA2xx, done_inrt 1 cycle after done_spi, rd_inrt=16'h1234, err=0, rd_a2d unchanged.
2. req_inrt and req_a2d both held continuously -> grant order I,I,I,I,A,I,I,I,I,A; defer_cnt clears after each A2D grant.
3. req_a2d with done_spi never returned -> done_a2d at wrt+TIMEOUT+1 with err=1, rd_a2d still 0. A late done_spi injected afterwards -> no done pulse.
4. rst asserted 10 cycles into an inertial XFER -> next cycle all outputs 0, no done_inrt. A pending req_a2d after rst drops -> wrt 1 cycle later with cmd=cmd_a2d.
5. req_inrt dropped 2 cycles after grant and cmd_inrt changed -> cmd stays at the granted value, done_inrt still pulses.
6. Spurious done_spi in IDLE -> no done pulse, busy stays 0.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared definitions for the QuadCopter SPI arbitration logic.
package quad_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  // Transaction owner encoding
  localparam logic OWN_INRT = 1'b0;
  localparam logic OWN_A2D  = 1'b1;

  // Default tuning
  localparam int unsigned DEF_MAX_DEFER = 4;
  localparam int unsigned DEF_TIMEOUT   = 1024;
  localparam int unsigned DEF_TO_W      = 11;

endpackage

// File: rtl/spi_xact_arb.sv
// Shares one SPI transaction engine between the inertial (flight-critical) and
// A2D requesters. One transaction at a time; read data and a done pulse go back
// to the owner. A defer counter bounds A2D starvation and a timeout counter
// recovers from a hung SPI engine.
module spi_xact_arb
  import quad_pkg::*;
#(
  parameter int unsigned MAX_DEFER = DEF_MAX_DEFER,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
  parameter int unsigned TO_W      = DEF_TO_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_inrt,
  input  logic [15:0] cmd_inrt,
  output logic        done_inrt,
  output logic [15:0] rd_inrt,
  input  logic        req_a2d,
  input  logic [15:0] cmd_a2d,
  output logic        done_a2d,
  output logic [15:0] rd_a2d,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done_spi,
  input  logic [15:0] rd_spi,
  output logic        busy,
  output logic        err
);

  localparam int unsigned DC_W = (MAX_DEFER > 0) ? $clog2(MAX_DEFER + 1) : 1;

  state_t          state;
  logic            owner;
  logic [DC_W-1:0] defer_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            a2d_wins;
  logic            defer_full;

  // A2D wins when it is the only requester or inertial has used up its deferrals
  always_comb begin
    defer_full = (defer_cnt == DC_W'(MAX_DEFER));
    a2d_wins   = req_a2d & (~req_inrt | defer_full);
  end

  // Arbitration FSM with registered outputs and inline defer/timeout counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_INRT;
      defer_cnt <= '0;
      to_cnt    <= '0;
      wrt       <= 1'b0;
      cmd       <= 16'h0000;
      busy      <= 1'b0;
      err       <= 1'b0;
      done_inrt <= 1'b0;
      done_a2d  <= 1'b0;
      rd_inrt   <= 16'h0000;
      rd_a2d    <= 16'h0000;
    end else begin
      // Pulsed outputs default low each cycle
      wrt       <= 1'b0;
      done_inrt <= 1'b0;
      done_a2d  <= 1'b0;
      err       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_inrt || req_a2d) begin
            owner  <= a2d_wins ? OWN_A2D : OWN_INRT;
            cmd    <= a2d_wins ? cmd_a2d : cmd_inrt;
            wrt    <= 1'b1;
            busy   <= 1'b1;
            to_cnt <= '0;
            state  <= XFER;
            if (a2d_wins) begin
              defer_cnt <= '0;
            end else if (req_a2d && !defer_full) begin
              defer_cnt <= defer_cnt + DC_W'(1);
            end
          end
        end
        XFER: begin
          // A real completion in the same cycle as expiry still delivers data
          if (done_spi) begin
            if (owner == OWN_A2D) begin
              rd_a2d   <= rd_spi;
              done_a2d <= 1'b1;
            end else begin
              rd_inrt   <= rd_spi;
              done_inrt <= 1'b1;
            end
            busy  <= 1'b0;
            state <= RESP;
          end else if (to_cnt == TO_W'(TIMEOUT)) begin
            if (owner == OWN_A2D) begin
              done_a2d <= 1'b1;
            end else begin
              done_inrt <= 1'b1;
            end
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= RESP;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        RESP: begin
          // Guaranteed idle gap before the next grant
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
